// File: rtl/bf_loader.sv
// Brainfuck core program loader: streams host bytes into instruction RAM,
// optionally zero-fills data RAM (LOADER_CLEAR_EN), then hands both RAMs to the CPU.
module bf_loader #(
  parameter int          IA_WIDTH   = 11,
  parameter int          DA_WIDTH   = 11,
  parameter int          DD_WIDTH   = 8,
  parameter logic [7:0]  TERMINATOR = 8'h00
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                LOAD_REQ,
  input  logic [7:0]          HDIN,
  input  logic                HRDA,
  output logic                HACK,
  output logic                BUSY,
  output logic                ERR,
  output logic                CPU_RESET,
  input  logic [IA_WIDTH-1:0] CIA,
  input  logic                CIEN,
  input  logic [DA_WIDTH-1:0] CDA,
  input  logic [DD_WIDTH-1:0] CDDOUT,
  input  logic                CDEN,
  input  logic                CDWE,
  output logic [IA_WIDTH-1:0] IMA,
  output logic [7:0]          IMDOUT,
  output logic                IMEN,
  output logic                IMWE,
  output logic [DA_WIDTH-1:0] DMA,
  output logic [DD_WIDTH-1:0] DMDOUT,
  output logic                DMEN,
  output logic                DMWE
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CLEAR, S_RUN} state_e;

  state_e              state_q, state_d;
  logic [IA_WIDTH-1:0] cnt_q, cnt_d;
  logic                last_q, last_d;
  logic                hack_q, hack_d;
  logic                err_q, err_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                busy_q, busy_d;
  logic [IA_WIDTH-1:0] ima_q, ima_d;
  logic [7:0]          imdout_q, imdout_d;
  logic                imwr_q, imwr_d;
`ifdef LOADER_CLEAR_EN
  logic [DA_WIDTH-1:0] clr_q, clr_d;
  logic [DA_WIDTH-1:0] dma_q, dma_d;
  logic                dmwr_q, dmwr_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    hack_d    = 1'b0;
    err_d     = err_q;
    cpu_rst_d = cpu_rst_q;
    ima_d     = '0;
    imdout_d  = '0;
    imwr_d    = 1'b0;
`ifdef LOADER_CLEAR_EN
    clr_d     = clr_q;
    dma_d     = '0;
    dmwr_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: if (LOAD_REQ) begin
        state_d = S_LOAD;
        cnt_d   = '0;
        err_d   = 1'b0;
        last_d  = 1'b0;
      end
      S_LOAD: begin
        // last_q holds the state one extra cycle so the final HACK completes in LOAD
        if (last_q) begin
`ifdef LOADER_CLEAR_EN
          state_d = S_CLEAR;
          dma_d   = '0;
          dmwr_d  = 1'b1;
          clr_d   = DA_WIDTH'(1);
`else
          state_d   = S_RUN;
          cpu_rst_d = 1'b0;
`endif
        end else if (HRDA && !hack_q) begin
          hack_d   = 1'b1;
          imwr_d   = 1'b1;
          ima_d    = cnt_q;
          cnt_d    = cnt_q + IA_WIDTH'(1);
          last_d   = (HDIN == TERMINATOR) || (&cnt_q);
          imdout_d = (&cnt_q) ? TERMINATOR : HDIN;
          if ((&cnt_q) && (HDIN != TERMINATOR)) err_d = 1'b1;
        end
      end
`ifdef LOADER_CLEAR_EN
      S_CLEAR: begin
        // clr_q is the next address to write; wrapping to 0 means every word is done
        if (clr_q == '0) begin
          state_d   = S_RUN;
          cpu_rst_d = 1'b0;
        end else begin
          dma_d  = clr_q;
          dmwr_d = 1'b1;
          clr_d  = clr_q + DA_WIDTH'(1);
        end
      end
`endif
      S_RUN: if (LOAD_REQ) begin
        state_d   = S_LOAD;
        cpu_rst_d = 1'b1;
        cnt_d     = '0;
        err_d     = 1'b0;
        last_d    = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d = (state_d == S_LOAD) || (state_d == S_CLEAR);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      hack_q    <= 1'b0;
      err_q     <= 1'b0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      ima_q     <= '0;
      imdout_q  <= '0;
      imwr_q    <= 1'b0;
`ifdef LOADER_CLEAR_EN
      clr_q     <= '0;
      dma_q     <= '0;
      dmwr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      hack_q    <= hack_d;
      err_q     <= err_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      ima_q     <= ima_d;
      imdout_q  <= imdout_d;
      imwr_q    <= imwr_d;
`ifdef LOADER_CLEAR_EN
      clr_q     <= clr_d;
      dma_q     <= dma_d;
      dmwr_q    <= dmwr_d;
`endif
    end
  end

  logic run;
  assign run = (state_q == S_RUN);

  assign HACK      = hack_q;
  assign BUSY      = busy_q;
  assign ERR       = err_q;
  assign CPU_RESET = cpu_rst_q;
  assign IMA       = run ? CIA   : ima_q;
  assign IMDOUT    = run ? 8'h00 : imdout_q;
  assign IMEN      = run ? CIEN  : imwr_q;
  assign IMWE      = run ? 1'b0  : imwr_q;
  assign DMDOUT    = run ? CDDOUT : '0;
`ifdef LOADER_CLEAR_EN
  assign DMA       = run ? CDA  : dma_q;
  assign DMEN      = run ? CDEN : dmwr_q;
  assign DMWE      = run ? CDWE : dmwr_q;
`else
  assign DMA       = run ? CDA  : '0;
  assign DMEN      = run ? CDEN : 1'b0;
  assign DMWE      = run ? CDWE : 1'b0;
`endif

endmodule
